// File: rtl/control_unit_types_pkg.sv
// ============================================================================
// control_unit_types_pkg : shared types for the branch resolve path
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package control_unit_types_pkg;

  localparam int PR_IDX_W  = 2;
  localparam int PR_ADDR_W = 32;

  typedef struct packed {
    logic                 valid;
    logic                 isbr;
    logic                 prtaken;
    logic [PR_IDX_W-1:0]  prindex;
    logic [PR_ADDR_W-1:0] npc;
    logic [PR_ADDR_W-1:0] btarget;
  } branch_rec_t;

  typedef enum logic {
    BR_NORMAL   = 1'b0,
    BR_REDIRECT = 1'b1
  } brfsm_t;

endpackage

`default_nettype wire

// File: rtl/branch_track_stage.sv
// ============================================================================
// branch_track_stage : one pipeline record register; clear has priority
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module branch_track_stage
  import control_unit_types_pkg::*;
#(
  parameter type REC_T = branch_rec_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  REC_T d,
  output REC_T q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit : tracks IF predictions to MEM, trains the predictor and
// raises a one-cycle flush/redirect on a mispredict.
// Optional statistics counters: define BRANCH_STATS_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit
  import control_unit_types_pkg::*;
#(
  parameter int IDX_W  = PR_IDX_W,
  parameter int ADDR_W = PR_ADDR_W,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic              if_isbr,
  input  logic              if_prtaken,
  input  logic [IDX_W-1:0]  if_prindex,
  input  logic [ADDR_W-1:0] if_npc,
  input  logic [ADDR_W-1:0] if_btarget,
  input  logic              pipe_en,
  input  logic              ext_flush,
  input  logic              mm_taken,
  output logic              upd_en,
  output logic [IDX_W-1:0]  upd_index,
  output logic              upd_taken,
  output logic              flush,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       br_cnt,
  output logic [31:0]       mispred_cnt
);

  typedef struct packed {
    logic              valid;
    logic              isbr;
    logic              prtaken;
    logic [IDX_W-1:0]  prindex;
    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] btarget;
  } rec_t;

  brfsm_t            state;
  brfsm_t            state_next;
  rec_t              if_rec;
  rec_t              stage_d [STAGES];
  rec_t              stage_q [STAGES];
  rec_t              tail;
  logic              shift_en;
  logic              rec_clr;
  logic              resolve;
  logic              mispredict;
  logic [ADDR_W-1:0] fix_pc;
  logic [ADDR_W-1:0] pc_q;

  always_comb begin
    if_rec         = '0;
    if_rec.valid   = if_valid & if_isbr;
    if_rec.isbr    = if_isbr;
    if_rec.prtaken = if_prtaken;
    if_rec.prindex = if_prindex;
    if_rec.npc     = if_npc;
    if_rec.btarget = if_btarget;
  end

  // The redirect cycle owns the pipeline: records are wiped regardless of stalls.
  assign shift_en = pipe_en && (state == BR_NORMAL);
  assign rec_clr  = ext_flush || (state == BR_REDIRECT);

  generate
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_head
        assign stage_d[g] = if_rec;
      end else begin : g_link
        assign stage_d[g] = stage_q[g-1];
      end
      branch_track_stage #(.REC_T(rec_t)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift_en),
        .clr   (rec_clr),
        .d     (stage_d[g]),
        .q     (stage_q[g])
      );
    end
  endgenerate

  assign tail       = stage_q[STAGES-1];
  assign resolve    = (state == BR_NORMAL) && tail.valid && tail.isbr && pipe_en;
  assign mispredict = resolve && (mm_taken != tail.prtaken);
  assign fix_pc     = mm_taken ? tail.btarget : tail.npc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BR_NORMAL;
      pc_q  <= '0;
    end else begin
      state <= state_next;
      if (mispredict) begin
        pc_q <= {fix_pc[ADDR_W-1:2], 2'b00};
      end
    end
  end

  always_comb begin
    state_next  = state;
    upd_en      = 1'b0;
    upd_index   = '0;
    upd_taken   = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    case (state)
      BR_NORMAL: begin
        if (resolve) begin
          upd_en    = 1'b1;
          upd_index = tail.prindex;
          upd_taken = mm_taken;
        end
        if (mispredict) begin
          state_next = BR_REDIRECT;
        end
      end
      BR_REDIRECT: begin
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = pc_q;
        state_next  = BR_NORMAL;
      end
      default: state_next = BR_NORMAL;
    endcase
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] br_q;
  logic [31:0] mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      if (resolve && (br_q != 32'hFFFF_FFFF)) begin
        br_q <= br_q + 32'd1;
      end
      if (mispredict && (mis_q != 32'hFFFF_FFFF)) begin
        mis_q <= mis_q + 32'd1;
      end
    end
  end

  assign br_cnt      = br_q;
  assign mispred_cnt = mis_q;
`else
  assign br_cnt      = '0;
  assign mispred_cnt = '0;
`endif

endmodule

`default_nettype wire
